// File: rtl/forward_select_ctrl.sv
// forward_select_ctrl: RAM clock-enable source selector with gated reconfiguration and enable forwarding
module forward_select_ctrl #(
  parameter int N_LOCAL    = 4,
  parameter int N_GLOBAL   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  input  logic [1:0]          cfg_src_i,
  input  logic [3:0]          cfg_idx_i,
  input  logic [1:0]          cfg_fwd_i,
  input  logic [N_LOCAL-1:0]  local_en_i,
  input  logic [N_GLOBAL-1:0] global_en_i,
  input  logic                fwd_en_up_i,
  input  logic                fwd_en_low_i,
  output logic                ram_en_o,
  output logic                fwd_en_up_o,
  output logic                fwd_en_low_o,
  output logic                cfg_ack_o,
  output logic                cfg_err_o,
  output logic                busy_o,
  output logic [7:0]          active_cfg_o
);
  typedef enum logic [1:0] {RUN, GATE, SWITCH, SETTLE} state_t;
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  state_t     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] active_q, active_d, pend_q, pend_d;
  logic       ram_en_q, ram_en_d, fwd_up_q, fwd_up_d, fwd_low_q, fwd_low_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic [15:0] loc_pad, glb_pad;
  logic [7:0] cfg_new;
  logic [1:0] fwd_eff;
  logic       sel, idx_bad;
  assign loc_pad = 16'(local_en_i);
  assign glb_pad = 16'(global_en_i);
  assign cfg_new = {cfg_fwd_i, cfg_src_i, cfg_idx_i};
  assign sel = active_q[5:4] == 2'd0 ? loc_pad[active_q[3:0]] :
               active_q[5:4] == 2'd1 ? glb_pad[active_q[3:0]] :
               active_q[5:4] == 2'd2 ? fwd_en_low_i : fwd_en_up_i;
  assign idx_bad = (cfg_src_i == 2'd0 && {1'b0, cfg_idx_i} >= 5'(N_LOCAL)) ||
                   (cfg_src_i == 2'd1 && {1'b0, cfg_idx_i} >= 5'(N_GLOBAL));
  // New forward routing applies during SWITCH so the outputs change right after it
  assign fwd_eff = state_q == SWITCH ? pend_q[7:6] : active_q[7:6];
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    active_d  = active_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    ram_en_d  = state_q == RUN && sel;
    fwd_low_d = fwd_eff[0] ? fwd_en_up_i : sel;
    fwd_up_d  = fwd_eff[1] ? fwd_en_low_i : sel;
    if (cfg_valid_i) begin
      if (state_q != RUN || idx_bad) err_d = 1'b1;
      else begin
        ack_d = 1'b1;
        if (cfg_new != active_q) begin
          pend_d  = cfg_new;
          state_d = GATE;
          gap_d   = GAP_LOAD;
        end
      end
    end
    case (state_q)
      GATE: begin
        if (gap_q == 4'd0) state_d = SWITCH;
        else gap_d = gap_q - 4'd1;
      end
      SWITCH: begin
        active_d = pend_q;
        state_d  = SETTLE;
        gap_d    = GAP_LOAD;
      end
      SETTLE: begin
        if (gap_q == 4'd0) state_d = RUN;
        else gap_d = gap_q - 4'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      gap_q     <= 4'd0;
      active_q  <= 8'd0;
      pend_q    <= 8'd0;
      ram_en_q  <= 1'b0;
      fwd_up_q  <= 1'b0;
      fwd_low_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      ram_en_q  <= ram_en_d;
      fwd_up_q  <= fwd_up_d;
      fwd_low_q <= fwd_low_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end
  assign ram_en_o     = ram_en_q;
  assign fwd_en_up_o  = fwd_up_q;
  assign fwd_en_low_o = fwd_low_q;
  assign cfg_ack_o    = ack_q;
  assign cfg_err_o    = err_q;
  assign busy_o       = state_q != RUN;
  assign active_cfg_o = active_q;
endmodule

// File: tb/tb_forward_select_ctrl.sv
// tb_forward_select_ctrl: directed checks of forward_select_ctrl with default parameters
module tb_forward_select_ctrl;
  logic       clk_i = 1'b0, rst_i = 1'b1, cfg_valid_i = 1'b0;
  logic [1:0] cfg_src_i = '0, cfg_fwd_i = '0;
  logic [3:0] cfg_idx_i = '0, local_en_i = 4'b0001, global_en_i = '0;
  logic       fwd_en_up_i = 1'b0, fwd_en_low_i = 1'b0;
  logic       ram_en_o, fwd_en_up_o, fwd_en_low_o, cfg_ack_o, cfg_err_o, busy_o;
  logic [7:0] active_cfg_o;
  int checks = 0, failures = 0;
  forward_select_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_src_i(cfg_src_i),
    .cfg_idx_i(cfg_idx_i), .cfg_fwd_i(cfg_fwd_i), .local_en_i(local_en_i),
    .global_en_i(global_en_i), .fwd_en_up_i(fwd_en_up_i), .fwd_en_low_i(fwd_en_low_i),
    .ram_en_o(ram_en_o), .fwd_en_up_o(fwd_en_up_o), .fwd_en_low_o(fwd_en_low_o),
    .cfg_ack_o(cfg_ack_o), .cfg_err_o(cfg_err_o), .busy_o(busy_o), .active_cfg_o(active_cfg_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [1:0] fwd, input logic [1:0] src, input logic [3:0] idx);
    cfg_valid_i = 1'b1;
    cfg_fwd_i = fwd;
    cfg_src_i = src;
    cfg_idx_i = idx;
  endtask
  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_ram", 8'(ram_en_o), 8'd0);
    chk("rst_busy", 8'(busy_o), 8'd0);
    chk("rst_active", active_cfg_o, 8'h00);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("run_ram", 8'(ram_en_o), 8'd1);
    chk("run_active", active_cfg_o, 8'h00);
    global_en_i = 4'b0100;
    req(2'd0, 2'd1, 4'd2);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    chk("sw1_ack", 8'(cfg_ack_o), 8'd1);
    chk("sw1_busy", 8'(busy_o), 8'd1);
    chk("sw1_ram_pre", 8'(ram_en_o), 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("sw1_gap%0d", i), 8'(ram_en_o), 8'd0);
      if (i == 0) chk("sw1_ack_off", 8'(cfg_ack_o), 8'd0);
    end
    @(negedge clk_i);
    chk("sw1_ram_post", 8'(ram_en_o), 8'd1);
    chk("sw1_active", active_cfg_o, 8'h12);
    chk("sw1_busy_off", 8'(busy_o), 8'd0);
    local_en_i = 4'b0010;
    req(2'd0, 2'd0, 4'd1);
    @(negedge clk_i);
    chk("sw2_ack", 8'(cfg_ack_o), 8'd1);
    req(2'd0, 2'd3, 4'd0);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    chk("sw2_err", 8'(cfg_err_o), 8'd1);
    chk("sw2_noack", 8'(cfg_ack_o), 8'd0);
    chk("sw2_active_mid", active_cfg_o, 8'h12);
    repeat (4) @(negedge clk_i);
    chk("sw2_busy_off", 8'(busy_o), 8'd0);
    @(negedge clk_i);
    chk("sw2_ram", 8'(ram_en_o), 8'd1);
    chk("sw2_active", active_cfg_o, 8'h01);
    req(2'd0, 2'd0, 4'd1);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    chk("same_ack", 8'(cfg_ack_o), 8'd1);
    chk("same_busy", 8'(busy_o), 8'd0);
    chk("same_ram", 8'(ram_en_o), 8'd1);
    req(2'd0, 2'd0, 4'd5);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    chk("bad_err", 8'(cfg_err_o), 8'd1);
    chk("bad_ack", 8'(cfg_ack_o), 8'd0);
    chk("bad_busy", 8'(busy_o), 8'd0);
    chk("bad_active", active_cfg_o, 8'h01);
    fwd_en_up_i = 1'b1;
    fwd_en_low_i = 1'b0;
    req(2'd3, 2'd0, 4'd1);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    chk("fwd_ack", 8'(cfg_ack_o), 8'd1);
    chk("fwd_up_local", 8'(fwd_en_up_o), 8'd1);
    chk("fwd_low_local", 8'(fwd_en_low_o), 8'd1);
    repeat (3) @(negedge clk_i);
    chk("fwd_up_switch", 8'(fwd_en_up_o), 8'd0);
    fwd_en_low_i = 1'b1;
    @(negedge clk_i);
    chk("fwd_up_gate1", 8'(fwd_en_up_o), 8'd1);
    chk("fwd_low_gate", 8'(fwd_en_low_o), 8'd1);
    chk("fwd_ram_gate1", 8'(ram_en_o), 8'd0);
    fwd_en_low_i = 1'b0;
    @(negedge clk_i);
    chk("fwd_up_gate0", 8'(fwd_en_up_o), 8'd0);
    chk("fwd_ram_gate0", 8'(ram_en_o), 8'd0);
    fwd_en_low_i = 1'b1;
    @(negedge clk_i);
    chk("fwd_up_run", 8'(fwd_en_up_o), 8'd1);
    chk("fwd_ram_run", 8'(ram_en_o), 8'd1);
    chk("fwd_active", active_cfg_o, 8'hC1);
    req(2'd0, 2'd0, 4'd2);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    chk("rs_ack", 8'(cfg_ack_o), 8'd1);
    repeat (3) @(negedge clk_i);
    chk("rs_busy_settle", 8'(busy_o), 8'd1);
    rst_i = 1'b1;
    local_en_i = 4'b0001;
    #1;
    chk("rs_busy", 8'(busy_o), 8'd0);
    chk("rs_ram", 8'(ram_en_o), 8'd0);
    chk("rs_fwd", {6'd0, fwd_en_up_o, fwd_en_low_o}, 8'd0);
    chk("rs_pulses", {6'd0, cfg_ack_o, cfg_err_o}, 8'd0);
    chk("rs_active", active_cfg_o, 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rs_post_active", active_cfg_o, 8'h00);
    chk("rs_post_busy", 8'(busy_o), 8'd0);
    chk("rs_post_ram", 8'(ram_en_o), 8'd1);
    @(negedge clk_i);
    chk("rs_post_busy2", 8'(busy_o), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
